// File: rtl/hwpe_ctrl_package.sv
// Shared types for the HWPE controller: uloop scheduler state and its
// control/flag bundles.
package hwpe_ctrl_package;

  localparam int unsigned ULOOP_SCHED_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FETCH,
    WAIT_FLAGS,
    LOAD,
    COMPUTE,
    STORE,
    FINISH
  } uloop_sched_state_t;

  typedef struct packed {
    logic start;
    logic clear;
  } ctrl_uloop_sched_t;

  typedef struct packed {
    logic                         busy;
    logic                         done_evt;
    logic [ULOOP_SCHED_CNT_W-1:0] tile_cnt;
  } flags_uloop_sched_t;

endpackage

// File: rtl/hwpe_ctrl_req_hold.sv
// Request generator: raised on set_i, held until the consumer acknowledges it.
module hwpe_ctrl_req_hold (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic set_i,
  input  logic ack_i,
  output logic req_o,
  output logic acc_o
);

  assign acc_o = req_o & ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       req_o <= 1'b0;
    else if (clear_i)  req_o <= 1'b0;
    else if (set_i)    req_o <= 1'b1;
    else if (acc_o)    req_o <= 1'b0;
  end

endmodule

// File: rtl/hwpe_ctrl_uloop_sched.sv
// Per-job tile scheduler: steps the uloop once per tile and runs the
// load / compute / store handshakes for each tile until the uloop is done.
//
// state      | meaning
// IDLE       | no job, waiting for start_i
// INIT       | uloop_clear_o pulse
// FETCH      | uloop_enable_o pulse (one uloop update)
// WAIT_FLAGS | waiting for uloop_valid_i, captures offsets and last flag
// LOAD       | load_req_o held until load_ack_i
// COMPUTE    | compute_start_o on entry, then waiting for compute_done_i
// STORE      | store_req_o held until store_ack_i, tile counted
// FINISH     | done_evt_o pulse
module hwpe_ctrl_uloop_sched
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned NB_REG         = 4,
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned TILE_CNT_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        start_i,
  output logic                        uloop_clear_o,
  output logic                        uloop_enable_o,
  input  logic                        uloop_valid_i,
  input  logic                        uloop_done_i,
  input  logic [NB_REG*REG_WIDTH-1:0] uloop_offs_i,
  output logic [NB_REG*REG_WIDTH-1:0] offs_o,
  output logic                        load_req_o,
  input  logic                        load_ack_i,
  output logic                        compute_start_o,
  input  logic                        compute_done_i,
  output logic                        store_req_o,
  input  logic                        store_ack_i,
  output logic                        busy_o,
  output logic                        done_evt_o,
  output logic [TILE_CNT_WIDTH-1:0]   tile_cnt_o
);

  uloop_sched_state_t state_q;
  ctrl_uloop_sched_t  ctrl;
  logic               last_q;
  logic               load_set, load_acc;
  logic               store_set, store_acc;

  assign ctrl.start = start_i;
  assign ctrl.clear = clear_i;

  assign busy_o = (state_q != IDLE);

  assign load_set  = (state_q == WAIT_FLAGS) && uloop_valid_i;
  // compute_start_o is high only in the COMPUTE entry cycle, so a done
  // coincident with the start pulse is masked here.
  assign store_set = (state_q == COMPUTE) && !compute_start_o && compute_done_i;

  hwpe_ctrl_req_hold i_load_req (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (ctrl.clear),
    .set_i   (load_set),
    .ack_i   (load_ack_i),
    .req_o   (load_req_o),
    .acc_o   (load_acc)
  );

  hwpe_ctrl_req_hold i_store_req (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (ctrl.clear),
    .set_i   (store_set),
    .ack_i   (store_ack_i),
    .req_o   (store_req_o),
    .acc_o   (store_acc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      last_q          <= 1'b0;
      uloop_clear_o   <= 1'b0;
      uloop_enable_o  <= 1'b0;
      compute_start_o <= 1'b0;
      done_evt_o      <= 1'b0;
      offs_o          <= '0;
      tile_cnt_o      <= '0;
    end else if (ctrl.clear) begin
      state_q         <= IDLE;
      last_q          <= 1'b0;
      uloop_clear_o   <= 1'b0;
      uloop_enable_o  <= 1'b0;
      compute_start_o <= 1'b0;
      done_evt_o      <= 1'b0;
      offs_o          <= '0;
      tile_cnt_o      <= '0;
    end else begin
      uloop_clear_o   <= 1'b0;
      uloop_enable_o  <= 1'b0;
      compute_start_o <= 1'b0;
      done_evt_o      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ctrl.start) begin
            state_q       <= INIT;
            uloop_clear_o <= 1'b1;
            tile_cnt_o    <= '0;
          end
        end
        INIT: begin
          state_q        <= FETCH;
          uloop_enable_o <= 1'b1;
        end
        FETCH: state_q <= WAIT_FLAGS;
        WAIT_FLAGS: begin
          if (uloop_valid_i) begin
            offs_o  <= uloop_offs_i;
            last_q  <= uloop_done_i;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (load_acc) begin
            state_q         <= COMPUTE;
            compute_start_o <= 1'b1;
          end
        end
        COMPUTE: begin
          if (store_set) state_q <= STORE;
        end
        STORE: begin
          if (store_acc) begin
            tile_cnt_o     <= tile_cnt_o + TILE_CNT_WIDTH'(1);
            state_q        <= last_q ? FINISH : FETCH;
            done_evt_o     <= last_q;
            uloop_enable_o <= !last_q;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_uloop_sched.sv
// Bench for the uloop tile scheduler: handshake-level reference model checked
// every cycle, plus directed jobs with literal expectations.
module tb_hwpe_ctrl_uloop_sched;

  localparam int unsigned NB_REG = 4;
  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned TCW = 2;
  localparam int unsigned OW = NB_REG * REG_WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_ni, clear_i, start_i;
  logic          uloop_clear_o, uloop_enable_o, uloop_valid_i, uloop_done_i;
  logic [OW-1:0] uloop_offs_i, offs_o;
  logic          load_req_o, load_ack_i, compute_start_o, compute_done_i;
  logic          store_req_o, store_ack_i, busy_o, done_evt_o;
  logic [TCW-1:0] tile_cnt_o;

  hwpe_ctrl_uloop_sched #(
    .NB_REG(NB_REG), .REG_WIDTH(REG_WIDTH), .TILE_CNT_WIDTH(TCW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .uloop_clear_o(uloop_clear_o), .uloop_enable_o(uloop_enable_o),
    .uloop_valid_i(uloop_valid_i), .uloop_done_i(uloop_done_i),
    .uloop_offs_i(uloop_offs_i), .offs_o(offs_o),
    .load_req_o(load_req_o), .load_ack_i(load_ack_i),
    .compute_start_o(compute_start_o), .compute_done_i(compute_done_i),
    .store_req_o(store_req_o), .store_ack_i(store_ack_i),
    .busy_o(busy_o), .done_evt_o(done_evt_o), .tile_cnt_o(tile_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // environment configuration
  int n_tiles = 1, ld_delay = 0, st_delay = 0, cd_delay = 1;
  bit tie_acks = 0, spur_valid = 0, spur_cd = 0;
  logic [OW-1:0] offs_tab [8];
  int  uidx = 0, lcnt = 0, scnt = 0, ccnt = 0;
  bit  pend = 0, carmed = 0;

  // observed event counters
  int n_en, n_uclear, n_done, n_ldcyc, n_stcyc;
  int ld_offs_q[$];
  int tile_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // uloop, streamer and engine responders; drive inputs mid-cycle
  always @(negedge clk_i) begin
    if (uloop_clear_o) uidx = 0;
    uloop_valid_i = 1'b0;
    uloop_done_i  = 1'b0;
    if (pend) begin
      uloop_valid_i = 1'b1;
      uloop_offs_i  = offs_tab[uidx % 8];
      uloop_done_i  = (uidx == n_tiles - 1);
      uidx++;
    end else if (spur_valid && store_req_o) begin
      uloop_valid_i = 1'b1;
      uloop_offs_i  = {4{32'hDEAD}};
      uloop_done_i  = 1'b1;
    end
    pend = uloop_enable_o;

    if (load_req_o) begin load_ack_i = tie_acks || (lcnt == ld_delay); lcnt++; end
    else begin load_ack_i = tie_acks; lcnt = 0; end
    if (store_req_o) begin store_ack_i = tie_acks || (scnt == st_delay); scnt++; end
    else begin store_ack_i = tie_acks; scnt = 0; end

    if (compute_start_o) begin
      ccnt = 0; carmed = 1; compute_done_i = spur_cd;
    end else if (carmed) begin
      ccnt++;
      compute_done_i = (ccnt == cd_delay);
      if (ccnt == cd_delay) carmed = 0;
    end else begin
      compute_done_i = 1'b0;
    end
  end

  // reference model: expected outputs derived from the handshake events seen at each edge
  logic m_uclear = 0, m_enable = 0, m_load = 0, m_cstart = 0, m_store = 0;
  logic m_busy = 0, m_done = 0, m_wait = 0, m_cwait = 0, m_last = 0;
  logic [TCW-1:0] m_tile = '0;
  logic [OW-1:0]  m_offs = '0;

  always @(posedge clk_i) begin
    logic clr, st_acc, cap, ld_acc, cdone, sd_acc;
    logic e_uclear, e_enable, e_load, e_cstart, e_store, e_busy, e_done, n_wait, n_cwait;
    #1;
    if (!rst_ni) begin
      {m_uclear, m_enable, m_load, m_cstart, m_store} = '0;
      {m_busy, m_done, m_wait, m_cwait, m_last} = '0;
      m_tile = '0;
      m_offs = '0;
    end else begin
      clr    = clear_i;
      st_acc = !m_busy && start_i;
      cap    = m_wait && uloop_valid_i;
      ld_acc = m_load && load_ack_i;
      cdone  = m_cwait && compute_done_i;
      sd_acc = m_store && store_ack_i;

      e_uclear = !clr && st_acc;
      e_enable = !clr && (m_uclear || (sd_acc && !m_last));
      n_wait   = !clr && (m_enable || (m_wait && !uloop_valid_i));
      e_load   = !clr && (cap || (m_load && !load_ack_i));
      e_cstart = !clr && ld_acc;
      n_cwait  = !clr && (m_cstart || (m_cwait && !compute_done_i));
      e_store  = !clr && (cdone || (m_store && !store_ack_i));
      e_done   = !clr && sd_acc && m_last;
      e_busy   = !clr && (st_acc || (m_busy && !m_done));
      if (clr || st_acc) m_tile = '0;
      else if (sd_acc)   m_tile = m_tile + 1'b1;
      if (clr)      begin m_offs = '0; m_last = 1'b0; end
      else if (cap) begin m_offs = uloop_offs_i; m_last = uloop_done_i; end

      if (e_load && !m_load) ld_offs_q.push_back(int'(offs_o[31:0]));
      if (sd_acc && !clr)    tile_q.push_back(int'(tile_cnt_o));

      {m_uclear, m_enable, m_load, m_cstart, m_store, m_busy, m_done} =
        {e_uclear, e_enable, e_load, e_cstart, e_store, e_busy, e_done};
      m_wait  = n_wait;
      m_cwait = n_cwait;

      checks++;
      if ({uloop_clear_o, uloop_enable_o, load_req_o, compute_start_o, store_req_o, busy_o, done_evt_o}
            !== {m_uclear, m_enable, m_load, m_cstart, m_store, m_busy, m_done}
          || tile_cnt_o !== m_tile || offs_o !== m_offs) begin
        errors++;
        $display("FAIL model t=%0t ctl(clr,en,ld,cs,st,busy,done) actual=%b required=%b tile actual=%0d required=%0d offs actual=%h required=%h",
                 $time,
                 {uloop_clear_o, uloop_enable_o, load_req_o, compute_start_o, store_req_o, busy_o, done_evt_o},
                 {m_uclear, m_enable, m_load, m_cstart, m_store, m_busy, m_done},
                 tile_cnt_o, m_tile, offs_o, m_offs);
      end

      if (uloop_enable_o) n_en++;
      if (uloop_clear_o)  n_uclear++;
      if (done_evt_o)     n_done++;
      if (load_req_o)     n_ldcyc++;
      if (store_req_o)    n_stcyc++;
    end
  end

  // main sequence runs at posedge+3
  task automatic step(input int n);
    repeat (n) begin @(posedge clk_i); #3; end
  endtask

  task automatic reset_counts();
    n_en = 0; n_uclear = 0; n_done = 0; n_ldcyc = 0; n_stcyc = 0;
    ld_offs_q.delete();
    tile_q.delete();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!done_evt_o && k < budget) begin step(1); k++; end
    if (!done_evt_o) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no done_evt required=done_evt within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_load(input int budget, input string tag);
    int k = 0;
    while (!load_req_o && k < budget) begin step(1); k++; end
    if (!load_req_o) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no load_req required=load_req within %0d cycles", tag, budget);
    end
  endtask

  task automatic run_job(input int nt, input string tag);
    n_tiles = nt;
    reset_counts();
    pulse_start();
    wait_done(400, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < 8; i++) offs_tab[i] = {4{32'(16 * (i + 1))}};
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    uloop_valid_i = 1'b0; uloop_done_i = 1'b0; uloop_offs_i = '0;
    load_ack_i = 1'b0; store_ack_i = 1'b0; compute_done_i = 1'b0;
    reset_counts();
    #23;
    chk("reset_ctl", 64'({uloop_clear_o, uloop_enable_o, load_req_o, compute_start_o, store_req_o, busy_o, done_evt_o}), 64'h0);
    chk("reset_tile", 64'(tile_cnt_o), 64'h0);
    chk("reset_offs", 64'(offs_o[63:0]), 64'h0);
    step(1);
    rst_ni = 1'b1;
    step(2);

    // three-tile job
    run_job(3, "three_tile");
    chk("three_tile_cnt", 64'(tile_cnt_o), 64'd3);
    chk("three_tile_offs_n", 64'(ld_offs_q.size()), 64'd3);
    if (ld_offs_q.size() == 3) begin
      chk("three_tile_offs0", 64'(ld_offs_q[0]), 64'h10);
      chk("three_tile_offs1", 64'(ld_offs_q[1]), 64'h20);
      chk("three_tile_offs2", 64'(ld_offs_q[2]), 64'h30);
    end
    step(1);
    chk("three_tile_busy_after", 64'(busy_o), 64'd0);
    chk("three_tile_done_cnt", 64'(n_done), 64'd1);
    chk("three_tile_en_cnt", 64'(n_en), 64'd3);
    chk("three_tile_offs_held", 64'(offs_o[31:0]), 64'h30);
    step(3);

    // single tile, every handshake answered immediately
    tie_acks = 1; cd_delay = 1;
    run_job(1, "single");
    chk("single_tile_cnt", 64'(tile_cnt_o), 64'd1);
    step(1);
    chk("single_en_cnt", 64'(n_en), 64'd1);
    chk("single_load_cycles", 64'(n_ldcyc), 64'd1);
    chk("single_store_cycles", 64'(n_stcyc), 64'd1);
    chk("single_done_cnt", 64'(n_done), 64'd1);
    tie_acks = 0;
    step(3);

    // back-pressure
    ld_delay = 7; st_delay = 3;
    run_job(2, "backpressure");
    step(1);
    chk("bp_load_cycles", 64'(n_ldcyc), 64'd16);
    chk("bp_store_cycles", 64'(n_stcyc), 64'd8);
    chk("bp_en_cnt", 64'(n_en), 64'd2);
    chk("bp_tile_cnt", 64'(tile_cnt_o), 64'd2);
    ld_delay = 0; st_delay = 0;
    step(3);

    // clear in COMPUTE of tile 2 of 4
    cd_delay = 5; n_tiles = 4;
    reset_counts();
    pulse_start();
    k = 0;
    while (!(compute_start_o && tile_cnt_o == 2'd1) && k < 200) begin step(1); k++; end
    chk("clear_reached_tile2", 64'(compute_start_o && tile_cnt_o == 2'd1), 64'd1);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    chk("clear_busy", 64'(busy_o), 64'd0);
    chk("clear_tile", 64'(tile_cnt_o), 64'd0);
    chk("clear_offs", 64'(offs_o[63:0]), 64'd0);
    step(10);
    chk("clear_no_done", 64'(n_done), 64'd0);
    cd_delay = 1;
    run_job(2, "after_clear");
    chk("after_clear_uclear", 64'(n_uclear), 64'd1);
    chk("after_clear_tile", 64'(tile_cnt_o), 64'd2);
    step(3);

    // spurious start, valid and coincident compute_done
    spur_valid = 1; spur_cd = 1; st_delay = 2; cd_delay = 3; n_tiles = 2;
    reset_counts();
    pulse_start();
    wait_load(50, "spur");
    pulse_start();
    wait_done(400, "spur");
    chk("spur_tile", 64'(tile_cnt_o), 64'd2);
    chk("spur_uclear", 64'(n_uclear), 64'd1);
    chk("spur_en", 64'(n_en), 64'd2);
    chk("spur_offs", 64'(offs_o[31:0]), 64'h20);
    step(1);
    chk("spur_done_cnt", 64'(n_done), 64'd1);
    spur_valid = 0; spur_cd = 0; st_delay = 0; cd_delay = 1;
    step(3);

    // tile counter wrap with a 2-bit counter
    run_job(5, "wrap");
    chk("wrap_store_acks", 64'(tile_q.size()), 64'd5);
    if (tile_q.size() == 5) begin
      chk("wrap_seq0", 64'(tile_q[0]), 64'd1);
      chk("wrap_seq1", 64'(tile_q[1]), 64'd2);
      chk("wrap_seq2", 64'(tile_q[2]), 64'd3);
      chk("wrap_seq3", 64'(tile_q[3]), 64'd0);
      chk("wrap_seq4", 64'(tile_q[4]), 64'd1);
    end
    chk("wrap_final", 64'(tile_cnt_o), 64'd1);
    step(3);

    // async reset mid-job
    ld_delay = 2; n_tiles = 3;
    reset_counts();
    pulse_start();
    wait_load(50, "areset");
    rst_ni = 1'b0;
    #1;
    chk("areset_ctl", 64'({uloop_clear_o, uloop_enable_o, load_req_o, compute_start_o, store_req_o, busy_o, done_evt_o}), 64'h0);
    chk("areset_offs", 64'(offs_o[63:0]), 64'h0);
    step(1);
    rst_ni = 1'b1;
    ld_delay = 0;
    step(2);
    run_job(1, "post_reset");
    chk("post_reset_tile", 64'(tile_cnt_o), 64'd1);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwpe_ctrl_uloop_sched.md
Name: hwpe_ctrl_uloop_sched

Overview:
- Per-job tile scheduler that sequences a shadowed uloop address generator against the streamer/engine datapath.
- On start, clears the uloop. For each tile it then:
  - requests one uloop update and latches the returned offsets;
  - drives load, compute and store phases with handshakes;
  - repeats until the uloop reports done.
- Sits between the register-file control FSM and the uloop/streamers inside an HWPE controller.

Parameters:
- NB_REG, 4, number of uloop offset registers forwarded to streamers
- REG_WIDTH, 32, width of each offset
- TILE_CNT_WIDTH, 16, width of the tile counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous abort/clear
- start_i  in  1  job start pulse
- uloop_clear_o  out  1  clear pulse to uloop
- uloop_enable_o  out  1  update request pulse to uloop
- uloop_valid_i  in  1  uloop flags valid (1 cycle after enable)
- uloop_done_i  in  1  returned flags belong to last iteration
- uloop_offs_i  in  NB_REG*REG_WIDTH  returned offsets
- offs_o  out  NB_REG*REG_WIDTH  latched offsets for current tile
- load_req_o  out  1  streamer load request
- load_ack_i  in  1  load accepted
- compute_start_o  out  1  engine start pulse
- compute_done_i  in  1  engine tile done pulse
- store_req_o  out  1  streamer store request
- store_ack_i  in  1  store accepted
- busy_o  out  1  job in progress
- done_evt_o  out  1  end-of-job event pulse
- tile_cnt_o  out  TILE_CNT_WIDTH  tiles completed in current job

Behaviour:
- Reset values:
  - all outputs 0, offs_o = 0, tile_cnt_o = 0, state IDLE;
  - internal last flag = 0.
- FSM states: IDLE, INIT, FETCH, WAIT_FLAGS, LOAD, COMPUTE, STORE, FINISH.
- IDLE:
  - start_i -> INIT; tile_cnt_o <= 0.
  - Other inputs ignored.
- INIT: uloop_clear_o = 1 for exactly one cycle -> FETCH.
- FETCH: uloop_enable_o = 1 for exactly one cycle -> WAIT_FLAGS.
- WAIT_FLAGS:
  - on uloop_valid_i: offs_o <= uloop_offs_i, last <= uloop_done_i -> LOAD.
  - offs_o stays stable from here until the next WAIT_FLAGS capture.
- LOAD:
  - load_req_o held high until load_ack_i is sampled high.
  - An ack in the first LOAD cycle counts.
  - -> COMPUTE.
- COMPUTE:
  - compute_start_o = 1 in the entry cycle only.
  - compute_done_i is sampled only from the following cycle; a done coincident with start is ignored.
  - On done -> STORE.
- STORE:
  - store_req_o held until store_ack_i.
  - On ack: tile_cnt_o increments, wrapping modulo 2^TILE_CNT_WIDTH.
  - Then -> FINISH if last, else -> FETCH.
- FINISH: done_evt_o = 1 for one cycle -> IDLE. tile_cnt_o and offs_o are held until the next start_i.
- busy_o = 1 in every state except IDLE; it is combinational from the state.
- Minimum per-tile latency: FETCH to WAIT_FLAGS capture to LOAD to COMPUTE, i.e. 5 cycles plus handshake waits.
- Boundary conditions:
  - start_i while busy: ignored.
  - uloop_valid_i outside WAIT_FLAGS: ignored.
  - load_ack_i, store_ack_i, compute_done_i outside their states: ignored, with no latching.
  - clear_i, any state: next cycle state = IDLE, req/pulse outputs 0, last = 0. tile_cnt_o and offs_o are cleared to 0. No done_evt_o is issued.
  - clear_i has priority over start_i in the same cycle.
  - Async reset mid-job: immediate return to the reset values.
- Single-tile job (uloop_done_i = 1 on the first valid): exactly one load/compute/store, then done_evt_o.

Decomposition:
- Shared hwpe_ctrl_package:
  - state enum type uloop_sched_state_t;
  - ctrl_uloop_sched_t struct {start, clear};
  - flags_uloop_sched_t struct {busy, done_evt, tile_cnt}.
- Single module; no sub-module needed.
- The req/ack phases use one local sub-block, hwpe_ctrl_req_hold: a hold-until-ack request generator, instantiated twice (load and store).

Test Plan:
- Three-tile job: start; uloop returns done = 0,0,1 with offs 0x10/0x20/0x30. Required response:
  - three load/compute/store sequences with offs_o = 0x10, 0x20, 0x30;
  - tile_cnt_o = 3;
  - one done_evt_o pulse;
  - busy_o falls in the cycle after done_evt_o.
- Single tile with immediate handshakes: all acks tied high, compute_done_i one cycle after start. Required response: uloop_enable_o exactly 1 time, load_req_o high exactly 1 cycle, done_evt_o after 1 tile.
- Back-pressure: load_ack_i delayed 7 cycles, store_ack_i 3 cycles. Required response: requests held continuously, offs_o stable, no extra uloop_enable_o.
- clear_i mid-COMPUTE on tile 2 of 4. Required response: next cycle IDLE, busy_o = 0, tile_cnt_o = 0, no done_evt_o. A following start restarts with uloop_clear_o.
- Spurious inputs: start_i during LOAD, uloop_valid_i during STORE, compute_done_i coincident with compute_start_o. Required response: all ignored, tile_cnt_o unaffected, FSM waits for the real compute_done_i.
- Wrap: TILE_CNT_WIDTH = 2, five-tile job. Required response: tile_cnt_o sequence 1,2,3,0,1; done_evt_o after 5th store ack.
